// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a circular byte FIFO; frames run back-to-back
// while bytes are queued and tx_en is high. count excludes the byte on the wire.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   tx_en,
  output logic                   tx,
  output logic                   busy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0]  BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [AW:0]     count_next;
  logic [7:0]      bit_cnt_reg;
  logic [7:0]      shift_reg;
  logic [2:0]      bit_idx_reg;
  logic            tx_reg;
  logic            busy_reg;
  logic            full_reg;
  logic            empty_reg;
  logic            overflow_reg;
  logic            wr_accept;
  logic            bit_done;
  logic            pop;

  // full/empty are the registered flags from before this edge, so a write
  // into a full FIFO is dropped even when a pop frees a slot at the same edge.
  assign wr_accept = wr_en & ~full_reg;
  assign bit_done  = (bit_cnt_reg == 8'd0);
  assign pop       = ~empty_reg & tx_en &
                     ((state_reg == IDLE) | ((state_reg == STOP) & bit_done));

  always_comb begin
    count_next = count_reg;
    if (wr_accept && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !wr_accept) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  // Storage carries no reset; clearing the pointers discards queued bytes.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      bit_cnt_reg  <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_CNT);
      empty_reg <= (count_next == '0);
      if (wr_en && full_reg) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (pop) begin
            shift_reg   <= mem[rd_ptr_reg];
            state_reg   <= START;
            tx_reg      <= 1'b0;
            busy_reg    <= 1'b1;
            bit_cnt_reg <= BIT_LAST;
          end
        end

        START: begin
          if (bit_done) begin
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
            bit_idx_reg <= 3'd0;
            bit_cnt_reg <= BIT_LAST;
          end else begin
            bit_cnt_reg <= bit_cnt_reg - 8'd1;
          end
        end

        DATA: begin
          if (bit_done) begin
            bit_cnt_reg <= BIT_LAST;
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              tx_reg    <= shift_reg[1];
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg - 8'd1;
          end
        end

        STOP: begin
          if (bit_done) begin
            // Next queued byte goes straight into its start bit, no idle gap.
            if (pop) begin
              shift_reg   <= mem[rd_ptr_reg];
              state_reg   <= START;
              tx_reg      <= 1'b0;
              bit_cnt_reg <= BIT_LAST;
            end else begin
              state_reg   <= IDLE;
              tx_reg      <= 1'b1;
              busy_reg    <= 1'b0;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg - 8'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_reg;
  assign busy     = busy_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a randomized
// run checked against a queue-and-frame-timer model of the transmitter.
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_en = 1'b0;
  logic       tx, busy, full, empty, overflow;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_en(tx_en),
    .tx(tx), .busy(busy), .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: queued bytes plus a cycle position within the current frame.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_tcnt = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;

  function automatic logic [FRAME-1:0] frame_vec(input logic [7:0] b);
    logic [9:0] w;
    logic [FRAME-1:0] v;
    w = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME; i++) v[i] = w[i / CPB];
    return v;
  endfunction

  function automatic logic m_tx();
    logic [9:0] w;
    w = {1'b1, m_cur, 1'b0};
    return m_active ? w[m_tcnt / CPB] : 1'b1;
  endfunction

  initial begin : ref_model
    bit frame_end, start_now, wr_ok;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_q.delete(); m_active = 1'b0; m_tcnt = 0; m_ovf = 1'b0;
      end else begin
        frame_end = m_active && (m_tcnt == FRAME - 1);
        start_now = (!m_active || frame_end) && (m_q.size() != 0) && (tx_en === 1'b1);
        wr_ok     = (wr_en === 1'b1) && (m_q.size() < DEPTH);
        if (wr_en === 1'b1 && !wr_ok) m_ovf = 1'b1;
        if (start_now) begin
          m_cur = m_q.pop_front(); m_active = 1'b1; m_tcnt = 0;
        end else if (frame_end) begin
          m_active = 1'b0;
        end else if (m_active) begin
          m_tcnt++;
        end
        if (wr_ok) m_q.push_back(wr_data);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0; wr_data = ~b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic capture_frame(output logic [FRAME-1:0] txv, output logic [FRAME-1:0] bv,
                               input int drop_at);
    for (int i = 0; i < FRAME; i++) begin
      txv[i] = tx; bv[i] = busy;
      if (i == drop_at) tx_en = 1'b0;
      tick();
    end
  endtask

  // Mid-bit sampling receiver; returns at the middle of the stop bit.
  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int w;
    b = '0; ok = 1'b0; w = 0;
    while (tx !== 1'b0 && w < 4 * FRAME) begin tick(); w++; end
    if (tx !== 1'b0) return;
    repeat (CPB / 2) tick();
    if (tx !== 1'b0) return;
    for (int k = 0; k < 8; k++) begin repeat (CPB) tick(); b[k] = tx; end
    repeat (CPB) tick();
    ok = (tx === 1'b1);
    $display("rx frame %02h", b);
  endtask

  task automatic test_reset();
    reset = 1'b0; tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
    repeat (3) tick();
    checks++;
    if ({tx, busy, full, empty, overflow, count} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 100100000", {tx, busy, full, empty, overflow, count});
    end
    wr_en = 1'b0; reset = 1'b1;
    repeat (20) tick();
    checks++;
    if ({tx, busy, empty, count} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_release_idle: got %b want 1010000", {tx, busy, empty, count});
    end
  endtask

  task automatic test_single_byte();
    logic [FRAME-1:0] txv, bv;
    tx_en = 1'b1;
    put(8'h31);
    checks++;
    if ({tx, busy, empty, count} !== {1'b1, 1'b0, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL single_after_write: got %b want 1000001", {tx, busy, empty, count});
    end
    tick();
    checks++;
    if ({tx, busy, count} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL single_start_latency: got %b want 010000", {tx, busy, count});
    end
    capture_frame(txv, bv, -1);
    $display("tx frame 31");
    checks++;
    if (txv !== frame_vec(8'h31)) begin
      errors++;
      $display("FAIL single_frame_bits: got %h want %h", txv, frame_vec(8'h31));
    end
    checks++;
    if (bv !== {FRAME{1'b1}}) begin
      errors++;
      $display("FAIL single_busy: got %h want all ones", bv);
    end
    checks++;
    if ({tx, busy, empty, count} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL single_end_idle: got %b want 1010000", {tx, busy, empty, count});
    end
  endtask

  task automatic test_back_to_back();
    logic [FRAME-1:0] t1, b1, t2, b2;
    tx_en = 1'b1;
    put(8'h55);
    put(8'hAA);
    checks++;
    if ({tx, busy, count} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL b2b_start: got %b want 010001", {tx, busy, count});
    end
    capture_frame(t1, b1, -1);
    capture_frame(t2, b2, -1);
    $display("tx frames 55 AA");
    checks++;
    if ({t2, t1} !== {frame_vec(8'hAA), frame_vec(8'h55)}) begin
      errors++;
      $display("FAIL b2b_frames: got %h_%h want %h_%h", t2, t1, frame_vec(8'hAA), frame_vec(8'h55));
    end
    checks++;
    if ({b2, b1} !== {(2 * FRAME){1'b1}}) begin
      errors++;
      $display("FAIL b2b_busy_gap: got %h_%h want all ones", b2, b1);
    end
    checks++;
    if ({tx, busy, empty} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_end_idle: got %b want 101", {tx, busy, empty});
    end
  endtask

  task automatic test_full_overflow();
    logic [FRAME-1:0] txv, bv;
    tx_en = 1'b0;
    for (int i = 0; i < 8; i++) put(8'(i));
    checks++;
    if ({full, overflow, tx, busy, count} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd8}) begin
      errors++;
      $display("FAIL full_after_8: got %b want 10101000", {full, overflow, tx, busy, count});
    end
    put(8'h08);
    checks++;
    if ({full, overflow, count} !== {1'b1, 1'b1, 4'd8}) begin
      errors++;
      $display("FAIL overflow_9th: got %b want 111000", {full, overflow, count});
    end
    tx_en = 1'b1;
    tick();
    checks++;
    if ({tx, full, count} !== {1'b0, 1'b0, 4'd7}) begin
      errors++;
      $display("FAIL full_drain_start: got %b want 000111", {tx, full, count});
    end
    for (int i = 0; i < 8; i++) begin
      capture_frame(txv, bv, -1);
      $display("tx frame %02h", i);
      checks++;
      if (txv !== frame_vec(8'(i))) begin
        errors++;
        $display("FAIL full_drain_frame%0d: got %h want %h", i, txv, frame_vec(8'(i)));
      end
    end
    checks++;
    if ({tx, busy, empty, overflow} !== 4'b1011) begin
      errors++;
      $display("FAIL full_end_sticky: got %b want 1011", {tx, busy, empty, overflow});
    end
    do_reset();
  endtask

  task automatic test_simultaneous();
    logic [FRAME-1:0] txv, bv;
    logic [7:0] bq [8];
    tx_en = 1'b1;
    for (int i = 0; i < 8; i++) bq[i] = 8'($urandom);
    put(8'hE0);
    for (int i = 0; i < 8; i++) put(bq[i]);
    repeat (FRAME - 8) tick();
    checks++;
    if ({tx, busy, full, overflow, count} !== {1'b1, 1'b1, 1'b1, 1'b0, 4'd8}) begin
      errors++;
      $display("FAIL simul_pre_pop: got %b want 11101000", {tx, busy, full, overflow, count});
    end
    wr_en = 1'b1; wr_data = 8'h7E;
    tick();
    wr_en = 1'b0;
    checks++;
    if ({tx, full, overflow, count} !== {1'b0, 1'b0, 1'b1, 4'd7}) begin
      errors++;
      $display("FAIL simul_full_pop_write: got %b want 0010111", {tx, full, overflow, count});
    end
    for (int i = 0; i < 8; i++) begin
      capture_frame(txv, bv, -1);
      $display("tx frame %02h", bq[i]);
      checks++;
      if (txv !== frame_vec(bq[i])) begin
        errors++;
        $display("FAIL simul_frame%0d: got %h want %h", i, txv, frame_vec(bq[i]));
      end
    end
    checks++;
    if ({tx, busy, empty} !== 3'b101) begin
      errors++;
      $display("FAIL simul_no_extra_frame: got %b want 101", {tx, busy, empty});
    end
    do_reset();
  endtask

  task automatic test_wrap();
    logic [7:0] cq [10];
    logic [7:0] rb [10];
    bit rok [10];
    for (int i = 0; i < 10; i++) cq[i] = 8'($urandom);
    tx_en = 1'b0;
    for (int i = 0; i < 3; i++) put(cq[i]);
    tx_en = 1'b1; wr_en = 1'b1; wr_data = cq[3];
    tick();
    wr_en = 1'b0;
    checks++;
    if ({tx, count} !== {1'b0, 4'd3}) begin
      errors++;
      $display("FAIL wrap_write_and_pop: got %b want 00011", {tx, count});
    end
    fork
      begin
        for (int i = 4; i < 9; i++) put(cq[i]);
        repeat (FRAME + 10) tick();
        put(cq[9]);
      end
      begin
        for (int i = 0; i < 10; i++) rx_byte(rb[i], rok[i]);
      end
    join
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (!rok[i] || rb[i] !== cq[i]) begin
        errors++;
        $display("FAIL wrap_byte%0d: got %02h ok=%0d want %02h", i, rb[i], rok[i], cq[i]);
      end
    end
    repeat (CPB) tick();
    checks++;
    if ({busy, empty, overflow, count} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL wrap_end: got %b want 0100000", {busy, empty, overflow, count});
    end
  endtask

  task automatic test_tx_en_mid_frame();
    logic [FRAME-1:0] txv, bv;
    logic [7:0] b;
    bit ok;
    tx_en = 1'b0;
    put(8'hD0); put(8'hD1); put(8'hD2);
    tx_en = 1'b1;
    tick();
    capture_frame(txv, bv, 40);
    checks++;
    if (txv !== frame_vec(8'hD0)) begin
      errors++;
      $display("FAIL txen_frame_completes: got %h want %h", txv, frame_vec(8'hD0));
    end
    repeat (30) tick();
    checks++;
    if ({tx, busy, count} !== {1'b1, 1'b0, 4'd2}) begin
      errors++;
      $display("FAIL txen_hold: got %b want 100010", {tx, busy, count});
    end
    tx_en = 1'b1;
    tick();
    checks++;
    if ({tx, busy, count} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL txen_restart: got %b want 010001", {tx, busy, count});
    end
    for (int i = 1; i < 3; i++) begin
      rx_byte(b, ok);
      checks++;
      if (!ok || b !== 8'(8'hD0 + i)) begin
        errors++;
        $display("FAIL txen_byte%0d: got %02h ok=%0d want %02h", i, b, ok, 8'(8'hD0 + i));
      end
    end
    repeat (CPB) tick();
  endtask

  task automatic test_reset_mid_frame(input int bit_no);
    logic [7:0] fb;
    logic [7:0] b;
    bit ok, seen;
    fb = 8'hF0;
    tx_en = 1'b0;
    put(8'hF0); put(8'h11); put(8'h22); put(8'h33);
    tx_en = 1'b1;
    tick();
    repeat (CPB + bit_no * CPB + CPB / 2) tick();
    checks++;
    if ({tx, count} !== {fb[bit_no], 4'd3}) begin
      errors++;
      $display("FAIL rstmid_bit%0d_pre: got %b want %b", bit_no, {tx, count}, {fb[bit_no], 4'd3});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tx, busy, full, empty, overflow, count} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL rstmid_bit%0d_async: got %b want 100100000", bit_no,
               {tx, busy, full, empty, overflow, count});
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if ({seen, count} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL rstmid_bit%0d_quiet: got activity=%0d count=%0d want 0 0", bit_no, seen, count);
    end
    put(8'h3C);
    rx_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h3C) begin
      errors++;
      $display("FAIL rstmid_bit%0d_new_write: got %02h ok=%0d want 3c", bit_no, b, ok);
    end
    repeat (CPB) tick();
  endtask

  task automatic test_random();
    logic [8:0] got, exp;
    int wr_pct, bad, w;
    bad = 0; wr_pct = 10;
    for (int cyc = 0; cyc < 4000 && bad < 5; cyc++) begin
      exp = {m_tx(), m_active, (m_q.size() == DEPTH), (m_q.size() == 0), m_ovf, 4'(m_q.size())};
      got = {tx, busy, full, empty, overflow, count};
      checks++;
      if (got !== exp) begin
        errors++; bad++;
        $display("FAIL random_cycle%0d: got %b want %b", cyc, got, exp);
      end
      if (cyc % 500 == 0) begin
        case ($urandom_range(0, 2))
          0: wr_pct = 3;
          1: wr_pct = 10;
          default: wr_pct = 40;
        endcase
      end
      if ($urandom_range(0, 299) == 0) tx_en = ~tx_en;
      wr_en = (int'($urandom_range(0, 99)) < wr_pct);
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0; tx_en = 1'b1;
    w = 0;
    while ((m_active || m_q.size() != 0) && w < (DEPTH + 2) * FRAME) begin tick(); w++; end
    tick();
    checks++;
    if ({tx, busy, empty, count} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL random_drain: got %b want 1010000", {tx, busy, empty, count});
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_overflow();
    test_simultaneous();
    test_wrap();
    test_tx_en_mid_frame();
    test_reset_mid_frame(4);
    test_reset_mid_frame(3);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
